// File: rtl/csa_group_accumulator.sv
// Carry-save group accumulator: each beat's operands fold into an (S,C) state through
// rows of 4:2 compressors; one exact carry-propagate add resolves each closed group.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder #(
  parameter int VARIANT = 4
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  if (VARIANT == 4) begin : g_mux
    // Propagate-select form: the carry is a mux steered by the propagate term.
    logic p;
    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = p ? cin : a;
  end else begin : g_logic
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
  end
endmodule

module compressor42 #(
  parameter int FA_VARIANT = 4
) (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);
  logic s1;
  full_adder #(.VARIANT(FA_VARIANT)) u_fa0 (.a(x1), .b(x2), .cin(x3), .sum(s1), .cout(cout));
  full_adder #(.VARIANT(FA_VARIANT)) u_fa1 (.a(s1), .b(x4), .cin(cin), .sum(sum), .cout(carry));
endmodule

module csa42_row #(
  parameter int W          = 24,
  parameter int FA_VARIANT = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);
  logic [W-1:0] carry;
  logic [W-1:0] cout;
  logic         msb_unused;

  for (genvar gi = 0; gi < W; gi++) begin : g_col
    if (gi == 0) begin : g_lsb
      // Nothing enters bit 0 laterally, so its second stage is a half adder.
      logic s1;
      full_adder #(.VARIANT(FA_VARIANT)) u_fa (.a(a[0]), .b(b[0]), .cin(c[0]), .sum(s1), .cout(cout[0]));
      half_adder u_ha (.a(s1), .b(d[0]), .sum(s[0]), .carry(carry[0]));
    end else begin : g_mid
      compressor42 #(.FA_VARIANT(FA_VARIANT)) u_c42 (
        .x1(a[gi]), .x2(b[gi]), .x3(c[gi]), .x4(d[gi]), .cin(cout[gi-1]),
        .sum(s[gi]), .carry(carry[gi]), .cout(cout[gi])
      );
    end
  end

  // Carry outputs of column i weigh 2^(i+1); the top column's carries wrap away.
  assign cy         = {carry[W-2:0], 1'b0};
  assign msb_unused = carry[W-1] ^ cout[W-1];
endmodule

module csa_group_accumulator #(
  parameter int IN_W       = 8,
  parameter int ACC_W      = 24,
  parameter int N_OPS      = 4,
  parameter bit IN_SIGNED  = 1'b1,
  parameter int APPROX_LSB = 0,
  parameter int CNT_W      = 8,
  parameter int FA_VARIANT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_OPS*IN_W-1:0]   in_ops,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic [CNT_W-1:0]        out_beats
);
  localparam int NV = N_OPS + 2;
  localparam logic [ACC_W-1:0] LO_MASK = {ACC_W{1'b1}} >> (ACC_W - APPROX_LSB);

  typedef enum logic [1:0] {ACC, RESOLVE, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] s_acc;
  logic [ACC_W-1:0] c_acc;  // carry vector stored already shifted to its column weight
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] ext_op [NV];
  logic [ACC_W-1:0] hi [NV];
  logic [ACC_W-1:0] lo_or, tree_s, tree_c;
  logic             accept;

  if (APPROX_LSB < 0 || APPROX_LSB > ACC_W) begin : g_bad_approx
    $error("APPROX_LSB must lie in 0..ACC_W");
  end

  // Approximate columns are OR-compressed off to the side; the tree sees them as zero,
  // so no carry can originate there or cross into the first exact column.
  always_comb begin
    for (int k = 0; k < N_OPS; k++) begin
      if (IN_SIGNED) ext_op[k] = ACC_W'($signed(in_ops[k*IN_W +: IN_W]));
      else           ext_op[k] = ACC_W'(in_ops[k*IN_W +: IN_W]);
    end
    ext_op[N_OPS]   = s_acc;
    ext_op[N_OPS+1] = c_acc;
    lo_or = '0;
    for (int k = 0; k < NV; k++) begin
      hi[k] = ext_op[k] & ~LO_MASK;
      lo_or = lo_or | (ext_op[k] & LO_MASK);
    end
  end

  if (N_OPS == 2) begin : g_tree2
    csa42_row #(.W(ACC_W), .FA_VARIANT(FA_VARIANT)) u_r0 (
      .a(hi[0]), .b(hi[1]), .c(hi[2]), .d(hi[3]), .s(tree_s), .cy(tree_c));
  end else if (N_OPS == 4) begin : g_tree4
    logic [ACC_W-1:0] s0, c0;
    csa42_row #(.W(ACC_W), .FA_VARIANT(FA_VARIANT)) u_r0 (
      .a(hi[0]), .b(hi[1]), .c(hi[2]), .d(hi[3]), .s(s0), .cy(c0));
    csa42_row #(.W(ACC_W), .FA_VARIANT(FA_VARIANT)) u_r1 (
      .a(s0), .b(c0), .c(hi[4]), .d(hi[5]), .s(tree_s), .cy(tree_c));
  end else if (N_OPS == 8) begin : g_tree8
    logic [ACC_W-1:0] s0, c0, s1, c1, s2, c2;
    csa42_row #(.W(ACC_W), .FA_VARIANT(FA_VARIANT)) u_r0 (
      .a(hi[0]), .b(hi[1]), .c(hi[2]), .d(hi[3]), .s(s0), .cy(c0));
    csa42_row #(.W(ACC_W), .FA_VARIANT(FA_VARIANT)) u_r1 (
      .a(hi[4]), .b(hi[5]), .c(hi[6]), .d(hi[7]), .s(s1), .cy(c1));
    csa42_row #(.W(ACC_W), .FA_VARIANT(FA_VARIANT)) u_r2 (
      .a(s0), .b(c0), .c(s1), .d(c1), .s(s2), .cy(c2));
    csa42_row #(.W(ACC_W), .FA_VARIANT(FA_VARIANT)) u_r3 (
      .a(s2), .b(c2), .c(hi[8]), .d(hi[9]), .s(tree_s), .cy(tree_c));
  end else begin : g_bad_ops
    $error("N_OPS must be 2, 4 or 8");
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      s_acc     <= '0;
      c_acc     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
    end else begin
      case (state)
        ACC: begin
          in_ready <= 1'b1;
          if (accept) begin
            s_acc <= tree_s | lo_or;
            c_acc <= tree_c;
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (in_last) begin
              in_ready <= 1'b0;
              state    <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          out_sum   <= s_acc + c_acc;
          out_beats <= cnt;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s_acc     <= '0;
            c_acc     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_group_accumulator.sv
// Bench for csa_group_accumulator: four parameterisations share one stimulus stream and
// are checked each cycle against an arithmetic group-sum model plus literal expectations.

module tb_csa_group_accumulator;
  localparam int NI = 4;  // 0 unsigned exact, 1 signed, 2 unsigned approx(2), 3 unsigned CNT_W=2

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_ops = '0;
  logic        rdy [NI];
  logic        vld [NI];
  logic [23:0] sum [NI];
  logic [7:0]  beats [NI];
  logic [1:0]  beats_c;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign beats[3] = {6'b0, beats_c};

  csa_group_accumulator #(.IN_SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_ops(in_ops),
    .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum[0]), .out_beats(beats[0]));
  csa_group_accumulator #(.IN_SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_ops(in_ops),
    .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum[1]), .out_beats(beats[1]));
  csa_group_accumulator #(.IN_SIGNED(1'b0), .APPROX_LSB(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_ops(in_ops),
    .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum[2]), .out_beats(beats[2]));
  csa_group_accumulator #(.IN_SIGNED(1'b0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_ops(in_ops),
    .in_last(in_last), .out_valid(vld[3]), .out_ready(out_ready), .out_sum(sum[3]), .out_beats(beats_c));

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [23:0] lomask(input int i);
    return (i == 2) ? 24'h000003 : 24'h000000;
  endfunction

  function automatic int cmax(input int i);
    return (i == 3) ? 3 : 255;
  endfunction

  function automatic logic [23:0] extend(input logic [7:0] v, input int i);
    if (i == 1) return {{16{v[7]}}, v};
    return {16'h0000, v};
  endfunction

  // Model: exact sum of the non-approximate bits, OR of the approximate bits, beat count.
  bit          exp_ready = 1'b0;
  bit          exp_valid = 1'b0;
  bit          result_due = 1'b0;
  int          beats_acc = 0;
  logic [23:0] hi_acc [NI] = '{default: '0};
  logic [23:0] lo_acc [NI] = '{default: '0};
  logic [23:0] exp_sum [NI] = '{default: '0};
  int          exp_beats [NI] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ready = 1'b0; exp_valid = 1'b0; result_due = 1'b0; beats_acc = 0;
      for (int i = 0; i < NI; i++) begin
        hi_acc[i] = '0; lo_acc[i] = '0; exp_sum[i] = '0; exp_beats[i] = 0;
      end
    end else if (exp_valid) begin
      if (out_ready) begin
        exp_valid = 1'b0; exp_ready = 1'b1; beats_acc = 0;
        for (int i = 0; i < NI; i++) begin hi_acc[i] = '0; lo_acc[i] = '0; end
      end
    end else if (result_due) begin
      result_due = 1'b0;
      exp_valid  = 1'b1;
      for (int i = 0; i < NI; i++) begin
        exp_sum[i]   = (hi_acc[i] & ~lomask(i)) | lo_acc[i];
        exp_beats[i] = (beats_acc > cmax(i)) ? cmax(i) : beats_acc;
      end
    end else if (!exp_ready) begin
      exp_ready = 1'b1;
    end else if (in_valid) begin
      beats_acc++;
      for (int i = 0; i < NI; i++)
        for (int k = 0; k < 4; k++) begin
          hi_acc[i] = hi_acc[i] + (extend(in_ops[k*8 +: 8], i) & ~lomask(i));
          lo_acc[i] = lo_acc[i] | (extend(in_ops[k*8 +: 8], i) & lomask(i));
        end
      if (in_last) begin result_due = 1'b1; exp_ready = 1'b0; end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("in_ready", i, 32'(rdy[i]), 32'(exp_ready));
      chk("out_valid", i, 32'(vld[i]), 32'(exp_valid));
      chk("out_sum", i, 32'(sum[i]), 32'(exp_sum[i]));
      chk("out_beats", i, 32'(beats[i]), 32'(exp_beats[i]));
    end
  end

  logic [23:0] cap_sum [NI];
  logic [7:0]  cap_beats [NI];
  int          cap_lat;

  task automatic send(input int a, input int b, input int c, input int d, input bit last);
    bit done = 1'b0;
    in_ops   = {8'(d), 8'(c), 8'(b), 8'(a)};
    in_valid = 1'b1;
    in_last  = last;
    for (int n = 0; n < 20 && !done; n++) begin
      if (rdy[0]) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("beat_accepted", 0, 32'(done), 32'd1);
  endtask

  task automatic collect();
    cap_lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (vld[0]) begin cap_lat = n; break; end
      @(negedge clk);
    end
    chk("result_seen", 0, 32'(cap_lat >= 0), 32'd1);
    for (int i = 0; i < NI; i++) begin
      cap_sum[i]   = sum[i];
      cap_beats[i] = beats[i];
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", 0, 32'(rdy[0]), 32'd0);
    chk("reset_valid", 0, 32'(vld[0]), 32'd0);
    chk("reset_sum", 0, 32'(sum[0]), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 0, 32'(rdy[0]), 32'd1);

    // Exact unsigned two-beat group with latency check
    send(1, 2, 3, 4, 1'b0);
    send(10, 20, 30, 40, 1'b1);
    collect();
    chk("t1_latency", 0, 32'(cap_lat), 32'd1);
    chk("t1_sum", 0, 32'(cap_sum[0]), 32'd110);
    chk("t1_beats", 0, 32'(cap_beats[0]), 32'd2);

    // Signed wrap
    repeat (2) send(-128, -128, -128, -128, 1'b0);
    send(-128, -128, -128, -128, 1'b1);
    collect();
    chk("t2_sum", 1, 32'(cap_sum[1]), 32'h00FFFA00);
    chk("t2_beats", 1, 32'(cap_beats[1]), 32'd3);
    send(127, 0, 0, 0, 1'b1);
    collect();
    chk("t2_sum_pos", 1, 32'(cap_sum[1]), 32'd127);

    // Approximate low columns versus exact
    send(1, 1, 1, 1, 1'b1);
    collect();
    chk("t3_approx", 2, 32'(cap_sum[2]), 32'd1);
    chk("t3_exact", 0, 32'(cap_sum[0]), 32'd4);

    // Backpressure in HOLD with a pending beat held by the source
    in_ops = {8'd5, 8'd5, 8'd5, 8'd5}; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 10 && !vld[0]; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      chk("t4_ready_low", 0, 32'(rdy[0]), 32'd0);
      chk("t4_valid", 0, 32'(vld[0]), 32'd1);
      chk("t4_sum_stable", 0, 32'(sum[0]), 32'd20);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_back", 0, 32'(rdy[0]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    collect();
    chk("t4_next_sum", 0, 32'(cap_sum[0]), 32'd20);
    chk("t4_next_beats", 0, 32'(cap_beats[0]), 32'd1);

    // Beat counter saturation
    repeat (5) send(1, 0, 0, 0, 1'b0);
    send(1, 0, 0, 0, 1'b1);
    collect();
    chk("t5_sum", 3, 32'(cap_sum[3]), 32'd6);
    chk("t5_beats_sat", 3, 32'(cap_beats[3]), 32'd3);
    chk("t5_beats_wide", 0, 32'(cap_beats[0]), 32'd6);

    // Asynchronous reset in the middle of a group
    repeat (2) send(7, 7, 7, 7, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_in_reset", 0, 32'(vld[0]), 32'd0);
    chk("t6_ready_in_reset", 0, 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 0, 0, 0, 1'b1);
    collect();
    chk("t6_sum", 0, 32'(cap_sum[0]), 32'd1);
    chk("t6_beats", 0, 32'(cap_beats[0]), 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
